layer_sequencer: RTL
====================

Name: layer_sequencer

Overview:
- Parametrised, runtime-configurable controller for one fully connected network layer.
- Fetches a bias and packed weight words from weight memory over a req/valid handshake, and reads LANES-wide activation groups from the activation buffer.
- Drives the MAC/sigmoid ALU and writes one result per neuron to the result buffer.
- The top-level network FSM issues one start per layer, with per-layer sizes and base address, so one instance serves every layer.

Parameters:
- LANES, 4, MAC lanes per accumulate; weights/inputs per memory word.
- DATA_W, 4, width of each weight, input, bias and result.
- ADDR_W, 16, weight memory address width.
- MAX_IN, 64, maximum input groups per neuron.
- MAX_OUT, 16, maximum neurons per layer.
- MAC_LAT, 3, cycles from last mac_accumulate to valid mac_result (must be ≥1).

Ports:
- clk  in  1  clock.
- n_rst  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle layer start request.
- abort  in  1  synchronous abort.
- cfg_n_in  in  $clog2(MAX_IN+1)  input groups per neuron.
- cfg_n_out  in  $clog2(MAX_OUT+1)  neurons in the layer.
- cfg_base  in  ADDR_W  address of the first bias word.
- mem_req  out  1  weight memory read request.
- mem_addr  out  ADDR_W  weight memory address.
- mem_valid  in  1  mem_data valid; accepts the current request.
- mem_data  in  LANES*DATA_W  weight word; bias is in bits [DATA_W-1:0].
- act_raddr  out  $clog2(MAX_IN)  activation group address; 1-cycle read latency.
- act_rdata  in  LANES*DATA_W  activation group.
- mac_clear  out  1  clear accumulator and load mac_bias.
- mac_accumulate  out  1  accumulate one lane group.
- mac_bias  out  DATA_W  registered bias.
- mac_weights  out  LANES*DATA_W  registered weights.
- mac_inputs  out  LANES*DATA_W  registered inputs.
- mac_result  in  DATA_W  activated neuron output.
- res_we  out  1  result write strobe.
- res_addr  out  $clog2(MAX_OUT)  result address (neuron index).
- res_data  out  DATA_W  result data.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse after the last result write.
- cfg_err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset: state IDLE; every output and register is 0, including mem_addr, counters, mac_* registers and res_*.
- States: IDLE, REQ_BIAS, REQ_W, ACCU, DRAIN, WRITE, DONE.
- IDLE:
  - start with 1≤cfg_n_in≤MAX_IN and 1≤cfg_n_out≤MAX_OUT latches the config, loads the address counter with cfg_base, clears the neuron and group counters, and moves to REQ_BIAS.
  - start with an out-of-range config pulses cfg_err and stays in IDLE.
  - start while busy is ignored.
- REQ_BIAS:
  - mem_req=1 with mem_addr held until mem_valid; mem_valid is allowed in the same cycle as the request.
  - On mem_valid: mac_bias<=mem_data[DATA_W-1:0], mac_clear=1 that cycle, address+1, go to REQ_W.
- REQ_W:
  - mem_req=1; act_raddr=group counter, stable since at least the previous cycle, so act_rdata is valid.
  - On mem_valid: mac_weights<=mem_data, mac_inputs<=act_rdata, address+1, go to ACCU.
- ACCU:
  - mac_accumulate=1 for one cycle; group+1.
  - If the group just processed was cfg_n_in-1: clear group, go to DRAIN; otherwise go to REQ_W.
- DRAIN: wait exactly MAC_LAT cycles, then go to WRITE.
- WRITE:
  - res_we=1, res_addr=neuron, res_data=mac_result.
  - If neuron==cfg_n_out-1 go to DONE; otherwise neuron+1 and go to REQ_BIAS.
- DONE: done=1 for one cycle, then IDLE.
- Memory layout per neuron: 1 bias word followed by cfg_n_in weight words, contiguous. Layer total is cfg_n_out*(cfg_n_in+1) words from cfg_base; mem_addr wraps modulo 2^ADDR_W.
- mem_req is never deasserted before mem_valid except by abort. mem_valid while mem_req=0 is ignored.
- Abort:
  - In any non-IDLE state, abort forces IDLE next cycle: mem_req=0, no write, no done, counters cleared.
  - Abort in the same cycle as an accept: the accepted data is discarded.
  - Abort with start in IDLE: abort wins, no start.
- Latency with zero-wait memory: 1 + 2*cfg_n_in + MAC_LAT + 1 cycles per neuron, plus 1 DONE cycle.

Test Plan:
- Reset mid-layer (n_rst low in REQ_W) -> all outputs 0, state IDLE; a subsequent start runs normally from cfg_base.
- cfg_n_in=2, cfg_n_out=3, cfg_base=0x0100, zero-wait memory, MAC_LAT=3, start accepted in cycle 0:
  - Bias/weight reads at addresses 0x0100..0x0108 in order.
  - res_we at addresses 0,1,2, with the address-0 write in cycle 9.
  - done pulses in cycle 28.
- Memory with random 0-5 cycle mem_valid delay, cfg_n_in=4, cfg_n_out=2 -> mem_addr stable while mem_req=1; exactly 10 accepts; results match the reference model; exactly one done.
- cfg_n_in=0, and separately cfg_n_out=17 -> cfg_err pulses once, busy stays 0, no mem_req.
- abort asserted in DRAIN of neuron 1 -> busy 0 next cycle, no res_we for neuron 1, no done; restart with cfg_base=0xFFFE, cfg_n_in=1, cfg_n_out=2 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- start asserted while busy, and abort+start together in IDLE -> both ignored; the in-flight layer is unaffected.

Source files
------------

// File: rtl/layer_sequencer.sv
// Sequencer for one fully connected layer: fetches bias and weight words, pairs them
// with activation groups, drives the MAC/sigmoid ALU and writes one result per neuron.
module layer_sequencer #(
    parameter int LANES   = 4,
    parameter int DATA_W  = 4,
    parameter int ADDR_W  = 16,
    parameter int MAX_IN  = 64,
    parameter int MAX_OUT = 16,
    parameter int MAC_LAT = 3,
    localparam int INW = $clog2(MAX_IN + 1),
    localparam int OUTW = $clog2(MAX_OUT + 1),
    localparam int GW = (MAX_IN > 1) ? $clog2(MAX_IN) : 1,
    localparam int NW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1,
    localparam int WW = LANES * DATA_W
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              abort,
    input  logic [INW-1:0]    cfg_n_in,
    input  logic [OUTW-1:0]   cfg_n_out,
    input  logic [ADDR_W-1:0] cfg_base,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [WW-1:0]     mem_data,
    output logic [GW-1:0]     act_raddr,
    input  logic [WW-1:0]     act_rdata,
    output logic              mac_clear,
    output logic              mac_accumulate,
    output logic [DATA_W-1:0] mac_bias,
    output logic [WW-1:0]     mac_weights,
    output logic [WW-1:0]     mac_inputs,
    input  logic [DATA_W-1:0] mac_result,
    output logic              res_we,
    output logic [NW-1:0]     res_addr,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);
    localparam int DRW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [INW-1:0]  MAX_IN_C  = INW'(MAX_IN);
    localparam logic [OUTW-1:0] MAX_OUT_C = OUTW'(MAX_OUT);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ_BIAS, S_REQ_W, S_ACCU, S_DRAIN, S_WRITE, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [INW-1:0]    n_in_q, n_in_d;
    logic [OUTW-1:0]   n_out_q, n_out_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [GW-1:0]     group_q, group_d;
    logic [NW-1:0]     neuron_q, neuron_d;
    logic [DRW-1:0]    drain_q, drain_d;
    logic [DATA_W-1:0] bias_q, bias_d;
    logic [WW-1:0]     wts_q, wts_d;
    logic [WW-1:0]     ins_q, ins_d;

    logic cfg_ok, last_grp, last_neuron;

    assign cfg_ok = (cfg_n_in != '0) && (cfg_n_in <= MAX_IN_C) &&
                    (cfg_n_out != '0) && (cfg_n_out <= MAX_OUT_C);
    assign last_grp    = INW'(group_q) == (n_in_q - INW'(1));
    assign last_neuron = OUTW'(neuron_q) == (n_out_q - OUTW'(1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            n_in_q   <= '0;
            n_out_q  <= '0;
            addr_q   <= '0;
            group_q  <= '0;
            neuron_q <= '0;
            drain_q  <= '0;
            bias_q   <= '0;
            wts_q    <= '0;
            ins_q    <= '0;
        end else begin
            state_q  <= state_d;
            n_in_q   <= n_in_d;
            n_out_q  <= n_out_d;
            addr_q   <= addr_d;
            group_q  <= group_d;
            neuron_q <= neuron_d;
            drain_q  <= drain_d;
            bias_q   <= bias_d;
            wts_q    <= wts_d;
            ins_q    <= ins_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        n_in_d   = n_in_q;
        n_out_d  = n_out_q;
        addr_d   = addr_q;
        group_d  = group_q;
        neuron_d = neuron_q;
        drain_d  = drain_q;
        bias_d   = bias_q;
        wts_d    = wts_q;
        ins_d    = ins_q;
        // Abort outranks everything, including a same-cycle memory accept.
        if (abort && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            addr_d   = '0;
            group_d  = '0;
            neuron_d = '0;
            drain_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: if (start && !abort && cfg_ok) begin
                    n_in_d   = cfg_n_in;
                    n_out_d  = cfg_n_out;
                    addr_d   = cfg_base;
                    group_d  = '0;
                    neuron_d = '0;
                    state_d  = S_REQ_BIAS;
                end
                S_REQ_BIAS: if (mem_valid) begin
                    bias_d  = mem_data[DATA_W-1:0];
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_REQ_W;
                end
                S_REQ_W: if (mem_valid) begin
                    wts_d   = mem_data;
                    ins_d   = act_rdata;
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_ACCU;
                end
                S_ACCU: if (last_grp) begin
                    group_d = '0;
                    drain_d = '0;
                    state_d = S_DRAIN;
                end else begin
                    group_d = group_q + GW'(1);
                    state_d = S_REQ_W;
                end
                S_DRAIN: if (drain_q == DRW'(MAC_LAT - 1)) state_d = S_WRITE;
                         else drain_d = drain_q + DRW'(1);
                S_WRITE: if (last_neuron) state_d = S_DONE;
                         else begin
                             neuron_d = neuron_q + NW'(1);
                             state_d  = S_REQ_BIAS;
                         end
                S_DONE: begin
                    neuron_d = '0;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // act_raddr follows the next group value so the 1-cycle buffer read has
    // already settled by the time REQ_W samples act_rdata.
    always_comb begin
        mem_req        = (state_q == S_REQ_BIAS) || (state_q == S_REQ_W);
        mem_addr       = addr_q;
        act_raddr      = group_d;
        mac_clear      = (state_q == S_REQ_BIAS) && mem_valid && !abort;
        mac_accumulate = (state_q == S_ACCU) && !abort;
        res_we         = (state_q == S_WRITE) && !abort;
        res_addr       = (state_q == S_WRITE) ? neuron_q : '0;
        res_data       = (state_q == S_WRITE) ? mac_result : '0;
        busy           = state_q != S_IDLE;
        done           = (state_q == S_DONE) && !abort;
        cfg_err        = (state_q == S_IDLE) && start && !abort && !cfg_ok;
    end

    assign mac_bias    = bias_q;
    assign mac_weights = wts_q;
    assign mac_inputs  = ins_q;
endmodule
